// File: rtl/reg_file_mp_if.sv
// ============================================================================
//  Module      : reg_file_mp_if
//  Description : Bundle of the register-file datapath signals.
//                master = decode/issue/writeback side (drives writes, read
//                addresses and scoreboard set); slave = register file.
//  Ports       : wen0/waddr0/wdata0/wstrb0, wen1/waddr1/wdata1/wstrb1,
//                raddr/rdata/rbusy (NUM_RD packed lanes), sb_set/sb_addr
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);
  logic                         wen0;
  logic [ADDR_WIDTH-1:0]        waddr0;
  logic [DATA_WIDTH-1:0]        wdata0;
  logic [DATA_WIDTH/8-1:0]      wstrb0;
  logic                         wen1;
  logic [ADDR_WIDTH-1:0]        waddr1;
  logic [DATA_WIDTH-1:0]        wdata1;
  logic [DATA_WIDTH/8-1:0]      wstrb1;
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rbusy;
  logic                         sb_set;
  logic [ADDR_WIDTH-1:0]        sb_addr;

  modport master (
    output wen0, waddr0, wdata0, wstrb0,
    output wen1, waddr1, wdata1, wstrb1,
    output raddr, sb_set, sb_addr,
    input  rdata, rbusy
  );

  modport slave (
    input  wen0, waddr0, wdata0, wstrb0,
    input  wen1, waddr1, wdata1, wstrb1,
    input  raddr, sb_set, sb_addr,
    output rdata, rbusy
  );
endinterface

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
//  Module      : reg_file_mp
//  Description : Multi-port register file with two byte-strobed write ports,
//                NUM_RD combinational read ports, optional write-to-read
//                bypass and a per-register busy scoreboard.
//  Ports       : clk  - clock, all state changes on posedge
//                rst  - synchronous active-high reset
//                bus  - reg_file_mp_if.slave (write ports, read ports,
//                       scoreboard set)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  reg_file_mp_if.slave  bus
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;
  localparam int c_NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [c_DEPTH-1:0]    r_busy;

  // Byte strobes expanded to bit masks so a merge is a plain AND/OR.
  logic [DATA_WIDTH-1:0] w_mask0;
  logic [DATA_WIDTH-1:0] w_mask1;

  always_comb begin
    w_mask0 = '0;
    w_mask1 = '0;
    for (int b = 0; b < c_NB; b++) begin
      w_mask0[b*8 +: 8] = {8{bus.wstrb0[b]}};
      w_mask1[b*8 +: 8] = {8{bus.wstrb1[b]}};
    end
  end

  // Value register `addr` takes at the next edge given its current value.
  // Port 1 is applied last, so it wins every byte it strobes.
  function automatic logic [DATA_WIDTH-1:0] f_merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [ADDR_WIDTH-1:0] addr
  );
    logic [DATA_WIDTH-1:0] v;
    v = old;
    if (bus.wen0 && (bus.waddr0 == addr))
      v = (v & ~w_mask0) | (bus.wdata0 & w_mask0);
    if (bus.wen1 && (bus.waddr1 == addr))
      v = (v & ~w_mask1) | (bus.wdata1 & w_mask1);
    return v;
  endfunction

  // An enabled write clears busy even with all strobes low: the producer
  // has retired regardless of how many bytes it touched.
  function automatic logic f_wr_hit(input logic [ADDR_WIDTH-1:0] addr);
    return (bus.wen0 && (bus.waddr0 == addr)) ||
           (bus.wen1 && (bus.waddr1 == addr));
  endfunction

  // --------------------------------------------------------------------------
  // Register array and scoreboard
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < c_DEPTH; a++) begin
        r_mem[a] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int a = 0; a < c_DEPTH; a++) begin
        if ((ZERO_REG != 0) && (a == 0)) begin
          r_mem[a]  <= '0;
          r_busy[a] <= 1'b0;
        end else begin
          r_mem[a] <= f_merge(r_mem[a], ADDR_WIDTH'(a));
          // A set in the same cycle as a clear means a newer producer was
          // issued, so the set takes priority.
          if (bus.sb_set && (bus.sb_addr == ADDR_WIDTH'(a)))
            r_busy[a] <= 1'b1;
          else if (f_wr_hit(ADDR_WIDTH'(a)))
            r_busy[a] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_val;

    assign w_ra = bus.raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      w_val = r_mem[w_ra];
      if (BYPASS != 0)
        w_val = f_merge(w_val, w_ra);
      if ((ZERO_REG != 0) && (w_ra == '0))
        w_val = '0;
    end

    assign bus.rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_val;
    // Busy is never bypassed: it reflects registered state only.
    assign bus.rbusy[k] = r_busy[w_ra];
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none

module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen0, wen1, sb_set;
  logic [4:0]  waddr0, waddr1, sb_addr;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  wstrb0, wstrb1;
  logic [9:0]  raddr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_mp_if bus_a ();
  reg_file_mp_if bus_b ();

  // Same stimulus to both instances; only the bypass option differs.
  assign bus_a.wen0 = wen0;     assign bus_b.wen0 = wen0;
  assign bus_a.waddr0 = waddr0; assign bus_b.waddr0 = waddr0;
  assign bus_a.wdata0 = wdata0; assign bus_b.wdata0 = wdata0;
  assign bus_a.wstrb0 = wstrb0; assign bus_b.wstrb0 = wstrb0;
  assign bus_a.wen1 = wen1;     assign bus_b.wen1 = wen1;
  assign bus_a.waddr1 = waddr1; assign bus_b.waddr1 = waddr1;
  assign bus_a.wdata1 = wdata1; assign bus_b.wdata1 = wdata1;
  assign bus_a.wstrb1 = wstrb1; assign bus_b.wstrb1 = wstrb1;
  assign bus_a.raddr = raddr;   assign bus_b.raddr = raddr;
  assign bus_a.sb_set = sb_set; assign bus_b.sb_set = sb_set;
  assign bus_a.sb_addr = sb_addr; assign bus_b.sb_addr = sb_addr;

  reg_file_mp #(.BYPASS(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  reg_file_mp #(.BYPASS(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // ---------------- reference model ----------------
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  function automatic logic [31:0] m_next(int a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_mem[a];
    for (int b = 0; b < 4; b++) begin
      if (wen0 && waddr0 == a && wstrb0[b]) v[b*8 +: 8] = wdata0[b*8 +: 8];
    end
    for (int b = 0; b < 4; b++) begin
      if (wen1 && waddr1 == a && wstrb1[b]) v[b*8 +: 8] = wdata1[b*8 +: 8];
    end
    return v;
  endfunction

  function automatic logic [31:0] m_read(int a, bit byp);
    if (a == 0) return 32'h0;
    return byp ? m_next(a) : m_mem[a];
  endfunction

  task automatic tick();
    logic [31:0] nxt [32];
    bit          nb  [32];
    @(posedge clk);
    for (int a = 0; a < 32; a++) begin
      nxt[a] = m_next(a);
      nb[a]  = m_busy[a];
      if (a != 0 && sb_set && sb_addr == a) nb[a] = 1'b1;
      else if ((wen0 && waddr0 == a) || (wen1 && waddr1 == a)) nb[a] = 1'b0;
      if (rst) begin
        nxt[a] = 32'h0;
        nb[a]  = 1'b0;
      end
    end
    for (int a = 0; a < 32; a++) begin
      m_mem[a]  = nxt[a];
      m_busy[a] = nb[a];
    end
    #1;
  endtask

  task automatic set_idle();
    wen0 = 0; waddr0 = 0; wdata0 = 0; wstrb0 = 0;
    wen1 = 0; waddr1 = 0; wdata1 = 0; wstrb1 = 0;
    sb_set = 0; sb_addr = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; set_idle(); raddr = {5'd6, 5'd5};
    tick(); tick();
    rst = 0; #1;
    n_tests++;
    if (bus_a.rdata !== 64'h0 || bus_a.rbusy !== 2'b00) begin
      n_fail++; $display("FAIL reset_state: rdata=%h rbusy=%b want 0/00", bus_a.rdata, bus_a.rbusy);
    end
    wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; wstrb0 = 4'hF;
    sb_set = 1; sb_addr = 6;
    tick(); set_idle(); #1;
    n_tests++;
    if (bus_b.rdata[31:0] !== 32'hDEADBEEF || bus_b.rbusy !== 2'b10) begin
      n_fail++; $display("FAIL reset_prewrite: r5=%h rbusy=%b want deadbeef/10", bus_b.rdata[31:0], bus_b.rbusy);
    end
    // Reset cycle with competing write and scoreboard set: reset must win.
    rst = 1; wen0 = 1; waddr0 = 5; wdata0 = 32'h55555555; wstrb0 = 4'hF;
    sb_set = 1; sb_addr = 5;
    tick(); rst = 0; set_idle(); #1;
    n_tests++;
    if (bus_b.rdata !== 64'h0 || bus_b.rbusy !== 2'b00) begin
      n_fail++; $display("FAIL reset_clear: rdata=%h rbusy=%b want 0/00", bus_b.rdata, bus_b.rbusy);
    end
  endtask

  task automatic test_byte_strobe();
    wen0 = 1; waddr0 = 3; wdata0 = 32'h11223344; wstrb0 = 4'hF;
    tick();
    wdata0 = 32'hAABBCCDD; wstrb0 = 4'b0101;
    tick(); set_idle(); raddr = {5'd3, 5'd3}; #1;
    n_tests++;
    if (bus_a.rdata[31:0] !== 32'h11BB33DD || bus_b.rdata[63:32] !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL byte_strobe: got %h/%h want 11bb33dd", bus_a.rdata[31:0], bus_b.rdata[63:32]);
    end
  endtask

  task automatic test_collision();
    wen0 = 1; waddr0 = 7; wdata0 = 32'h000000FF; wstrb0 = 4'b1111;
    wen1 = 1; waddr1 = 7; wdata1 = 32'h12345678; wstrb1 = 4'b0011;
    raddr = {5'd7, 5'd7}; #1;
    n_tests++;
    if (bus_a.rdata[63:32] !== 32'h00005678) begin
      n_fail++; $display("FAIL collision_bypass: got %h want 00005678", bus_a.rdata[63:32]);
    end
    tick(); set_idle(); #1;
    n_tests++;
    if (bus_b.rdata[31:0] !== 32'h00005678) begin
      n_fail++; $display("FAIL collision: got %h want 00005678", bus_b.rdata[31:0]);
    end
  endtask

  task automatic test_bypass();
    raddr = {5'd1, 5'd9};
    wen0 = 1; waddr0 = 9; wdata0 = 32'hCAFEF00D; wstrb0 = 4'hF; #1;
    n_tests++;
    if (bus_a.rdata[31:0] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL bypass_on: got %h want cafef00d", bus_a.rdata[31:0]);
    end
    n_tests++;
    if (bus_b.rdata[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL bypass_off_old: got %h want 00000000", bus_b.rdata[31:0]);
    end
    tick(); set_idle(); #1;
    n_tests++;
    if (bus_b.rdata[31:0] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL bypass_off_new: got %h want cafef00d", bus_b.rdata[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    raddr = 10'd0;
    wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF; wstrb0 = 4'hF;
    wen1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF; wstrb1 = 4'hF;
    sb_set = 1; sb_addr = 0; #1;
    n_tests++;
    if (bus_a.rdata !== 64'h0) begin
      n_fail++; $display("FAIL zero_bypass: got %h want 0", bus_a.rdata);
    end
    tick(); set_idle(); #1;
    n_tests++;
    if (bus_a.rdata !== 64'h0 || bus_b.rdata !== 64'h0 || bus_a.rbusy !== 2'b00 || bus_b.rbusy !== 2'b00) begin
      n_fail++; $display("FAIL zero_reg: rdata=%h/%h rbusy=%b/%b want 0", bus_a.rdata, bus_b.rdata, bus_a.rbusy, bus_b.rbusy);
    end
  endtask

  task automatic test_scoreboard();
    raddr = {5'd4, 5'd4};
    sb_set = 1; sb_addr = 4;
    tick(); set_idle(); #1;
    n_tests++;
    if (bus_a.rbusy !== 2'b11) begin
      n_fail++; $display("FAIL sb_set: rbusy=%b want 11", bus_a.rbusy);
    end
    wen0 = 1; waddr0 = 4; wdata0 = 32'h1; wstrb0 = 4'hF; sb_set = 1; sb_addr = 4;
    tick(); set_idle(); #1;
    n_tests++;
    if (bus_a.rbusy !== 2'b11) begin
      n_fail++; $display("FAIL sb_set_wins: rbusy=%b want 11", bus_a.rbusy);
    end
    // All strobes low still retires the producer.
    wen1 = 1; waddr1 = 4; wdata1 = 32'hFFFFFFFF; wstrb1 = 4'h0;
    tick(); set_idle(); #1;
    n_tests++;
    if (bus_a.rbusy !== 2'b00 || bus_b.rdata[31:0] !== 32'h1) begin
      n_fail++; $display("FAIL sb_clear: rbusy=%b r4=%h want 00/00000001", bus_a.rbusy, bus_b.rdata[31:0]);
    end
    sb_set = 1; sb_addr = 4;
    tick(); set_idle(); rst = 1;
    tick(); rst = 0; #1;
    n_tests++;
    if (bus_a.rbusy !== 2'b00) begin
      n_fail++; $display("FAIL sb_reset: rbusy=%b want 00", bus_a.rbusy);
    end
  endtask

  task automatic test_random();
    int ra;
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      wen0   = $urandom_range(0, 1);  waddr0 = 5'($urandom_range(0, 7));
      wdata0 = $urandom;              wstrb0 = 4'($urandom);
      wen1   = $urandom_range(0, 1);  waddr1 = 5'($urandom_range(0, 7));
      wdata1 = $urandom;              wstrb1 = 4'($urandom);
      sb_set = ($urandom_range(0, 2) == 0); sb_addr = 5'($urandom_range(0, 7));
      raddr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int k = 0; k < 2; k++) begin
        ra = int'(raddr[k*5 +: 5]);
        n_tests++;
        if (bus_a.rdata[k*32 +: 32] !== m_read(ra, 1'b1) ||
            bus_b.rdata[k*32 +: 32] !== m_read(ra, 1'b0)) begin
          n_fail++;
          $display("FAIL rand_rdata it%0d port%0d r%0d: got %h/%h want %h/%h", i, k, ra,
                   bus_a.rdata[k*32 +: 32], bus_b.rdata[k*32 +: 32], m_read(ra, 1'b1), m_read(ra, 1'b0));
        end
        n_tests++;
        if (bus_a.rbusy[k] !== m_busy[ra] || bus_b.rbusy[k] !== m_busy[ra]) begin
          n_fail++;
          $display("FAIL rand_rbusy it%0d port%0d r%0d: got %b/%b want %b", i, k, ra,
                   bus_a.rbusy[k], bus_b.rbusy[k], m_busy[ra]);
        end
      end
      tick();
    end
    rst = 0; set_idle();
  endtask

  initial begin
    for (int a = 0; a < 32; a++) begin
      m_mem[a]  = 32'h0;
      m_busy[a] = 1'b0;
    end
    test_reset();
    test_byte_strobe();
    test_collision();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
